// File: rtl/dmem_pkg.sv
// dmem_pkg: constants and state type shared by the line responder and the dcache controller
package dmem_pkg;
  localparam int LINE_W = 256;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int LATENCY_DEFAULT = 10;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: single-port synchronous line RAM with a registered, resettable read port
module dmem_line_array #(
  parameter int W = 256,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  // storage has no reset; contents survive a reset pulse
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;
  // read register only changes on a read commit, so it holds across write acks
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[idx];
endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: fixed-latency memory model answering dcache line reads and write-backs
module dmem_line_responder import dmem_pkg::*; #(
  parameter int LINE_W = dmem_pkg::LINE_W,
  parameter int DEPTH = 512,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_ack_o,
  output logic [LINE_W-1:0] mem_data_o
);
  localparam int IW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [7:0] cnt;
  logic wr_q;
  logic [IW-1:0] idx_q;
  logic [LINE_W-1:0] data_q;
  logic accept, commit, wr;
  logic [IW-1:0] idx;
  logic [LINE_W-1:0] wdata;
  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[31:LINE_OFFSET_BITS+IW], mem_addr_i[LINE_OFFSET_BITS-1:0]};
  assign accept = state == IDLE && mem_enable_i;
  // the ACK state is the commit cycle; the registered ack follows it one cycle later,
  // so the FSM is already back in IDLE while mem_ack_o is high
  assign commit = state_nx == ACK;
  // with LATENCY=1 the commit happens at the accept edge, so use live inputs then
  assign wr = accept ? mem_write_i : wr_q;
  assign idx = accept ? mem_addr_i[LINE_OFFSET_BITS +: IW] : idx_q;
  assign wdata = accept ? mem_data_i : data_q;
  // state register
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nx;
  // next state: accept in IDLE, count down in WAIT, single commit cycle in ACK
  always_comb begin
    state_nx = state;
    if (accept) state_nx = LATENCY == 1 ? ACK : WAIT;
    else if (state == WAIT && cnt == 8'd1) state_nx = ACK;
    else if (state == ACK) state_nx = IDLE;
  end
  // request latch, latency counter and registered ack
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cnt <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      data_q <= '0;
      mem_ack_o <= 1'b0;
    end else begin
      mem_ack_o <= state == ACK;
      if (accept) begin
        cnt <= 8'(LATENCY - 1);
        wr_q <= mem_write_i;
        idx_q <= mem_addr_i[LINE_OFFSET_BITS +: IW];
        data_q <= mem_data_i;
      end else if (state == WAIT) cnt <= cnt - 8'd1;
    end
  dmem_line_array #(.W(LINE_W), .DEPTH(DEPTH)) u_array (
    .clk(clk_i),
    .rst_n(rst_i),
    .we(commit & wr),
    .re(commit & ~wr),
    .idx(idx),
    .wdata(wdata),
    .rdata(mem_data_o)
  );
endmodule
